// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller. It freezes the pipeline on an L1 miss,
//   flushes IF/ID and ID/EX on a jump or taken branch, and inserts
//   LU_CYCLES bubbles on a load-use dependency. Three saturating
//   performance counters record these events.
//
// Parameters
//   ADDR_W     register-specifier width
//   LU_CYCLES  bubbles per load-use hazard (1..7)
//   CNT_W      performance-counter width
//
// Ports
//   clk, rst                         clock, async active-high reset
//   id_rs, id_rt, id_rs_used,
//   id_rt_used                       ID-stage source operands
//   ex_wr, ex_memtoreg, ex_jumpctrl,
//   branch                           EX-stage destination / control
//   icache_stall, dcache_stall       L1 miss in progress
//   clr_cnt                          synchronous counter clear
//   pc_write, if_write, id_write,
//   exmem_write                      pipeline-register enables
//   if_flush, id_flush               bubble insertion
//   state_o                          00 RUN, 01 LU_STALL, 10 MISS
//   lu_cnt, miss_cnt, flush_cnt      performance counters
module hazard_ctrl_unit #(
  parameter int ADDR_W    = 5,
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] ex_wr,
  input  logic              ex_memtoreg,
  input  logic [1:0]        ex_jumpctrl,
  input  logic              branch,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  input  logic              clr_cnt,
  output logic              pc_write,
  output logic              if_write,
  output logic              id_write,
  output logic              exmem_write,
  output logic              if_flush,
  output logic              id_flush,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  lu_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MISS     = 2'b10
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

  state_t     state, state_nx;
  state_t     saved, saved_nx;
  state_t     eff;
  logic [2:0] rem, rem_nx;
  logic       miss, redirect, luhit, lu_stall;

  assign miss     = icache_stall | dcache_stall;
  assign redirect = (ex_jumpctrl == 2'b01) | (ex_jumpctrl == 2'b10) |
                    ((ex_jumpctrl == 2'b11) & branch);
  assign luhit    = ex_memtoreg & (ex_wr != '0) &
                    ((id_rs_used & (id_rs == ex_wr)) |
                     (id_rt_used & (id_rt == ex_wr)));

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      saved <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
      rem   <= rem_nx;
    end
  end

  // While in MISS the saved state stands in for the real one, so leaving
  // a miss resumes exactly where the frozen state left off; rem is simply
  // not touched during the freeze.
  always_comb begin
    pc_write    = 1'b1;
    if_write    = 1'b1;
    id_write    = 1'b1;
    exmem_write = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    lu_stall    = 1'b0;
    state_nx    = state;
    saved_nx    = saved;
    rem_nx      = rem;
    eff         = (state == MISS) ? saved : state;

    if (miss) begin
      pc_write    = 1'b0;
      if_write    = 1'b0;
      id_write    = 1'b0;
      exmem_write = 1'b0;
      state_nx    = MISS;
      if (state != MISS) saved_nx = state;
    end else if (redirect) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      state_nx = RUN;
      rem_nx   = '0;
    end else if (eff == LU_STALL || luhit) begin
      pc_write = 1'b0;
      if_write = 1'b0;
      id_flush = 1'b1;
      lu_stall = 1'b1;
      if (eff == LU_STALL) begin
        if (rem <= 3'd1) begin
          state_nx = RUN;
          rem_nx   = '0;
        end else begin
          state_nx = LU_STALL;
          rem_nx   = rem - 3'd1;
        end
      end else if (LU_CYCLES > 1) begin
        state_nx = LU_STALL;
        rem_nx   = LU_INIT;
      end else begin
        state_nx = RUN;
      end
    end else begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt    <= '0;
      miss_cnt  <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      lu_cnt    <= '0;
      miss_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_stall && lu_cnt != '1)               lu_cnt    <= lu_cnt + 1'b1;
      if (miss && miss_cnt != '1)                 miss_cnt  <= miss_cnt + 1'b1;
      if (redirect && !miss && flush_cnt != '1)   flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LU_CYCLES=2/CNT_W=16 and
// LU_CYCLES=3/CNT_W=4) share one stimulus stream and are compared each
// cycle against a bubble-counting reference model.
module tb_hazard_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wr;
  logic       id_rs_used, id_rt_used, ex_memtoreg, branch;
  logic [1:0] ex_jumpctrl;
  logic       icache_stall, dcache_stall, clr_cnt;

  logic        pw2, iw2, dw2, ew2, iff2, idf2;
  logic [1:0]  st2;
  logic [15:0] lu2, mi2, fl2;
  logic        pw3, iw3, dw3, ew3, iff3, idf3;
  logic [1:0]  st3;
  logic [3:0]  lu3, mi3, fl3;

  int tests = 0;
  int fails = 0;

  int bl[2];
  bit inm[2];
  int lu[2], mi[2], fl[2];
  int lcy[2]  = '{2, 3};
  int cmax[2] = '{65535, 15};

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.ADDR_W(5), .LU_CYCLES(2), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_wr(ex_wr),
    .ex_memtoreg(ex_memtoreg), .ex_jumpctrl(ex_jumpctrl), .branch(branch),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall), .clr_cnt(clr_cnt),
    .pc_write(pw2), .if_write(iw2), .id_write(dw2), .exmem_write(ew2),
    .if_flush(iff2), .id_flush(idf2), .state_o(st2),
    .lu_cnt(lu2), .miss_cnt(mi2), .flush_cnt(fl2));

  hazard_ctrl_unit #(.ADDR_W(5), .LU_CYCLES(3), .CNT_W(4)) d3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_wr(ex_wr),
    .ex_memtoreg(ex_memtoreg), .ex_jumpctrl(ex_jumpctrl), .branch(branch),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall), .clr_cnt(clr_cnt),
    .pc_write(pw3), .if_write(iw3), .id_write(dw3), .exmem_write(ew3),
    .if_flush(iff3), .id_flush(idf3), .state_o(st3),
    .lu_cnt(lu3), .miss_cnt(mi3), .flush_cnt(fl3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_miss();
    return icache_stall || dcache_stall;
  endfunction

  function automatic bit m_redir();
    return (ex_jumpctrl == 2'd1) || (ex_jumpctrl == 2'd2) ||
           (ex_jumpctrl == 2'd3 && branch);
  endfunction

  function automatic bit m_luhit();
    return ex_memtoreg && ex_wr != 5'd0 &&
           ((id_rs_used && id_rs == ex_wr) || (id_rt_used && id_rt == ex_wr));
  endfunction

  // {pc_write, if_write, id_write, exmem_write, if_flush, id_flush}
  function automatic logic [5:0] m_out(int k);
    if (m_miss())                     return 6'b0000_00;
    if (m_redir())                    return 6'b1111_11;
    if (bl[k] > 0 || m_luhit())       return 6'b0011_01;
    return 6'b1111_00;
  endfunction

  function automatic logic [1:0] m_state(int k);
    if (inm[k])    return 2'd2;
    if (bl[k] > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bl[k] = 0; inm[k] = 0; lu[k] = 0; mi[k] = 0; fl[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit ms, rd, lh;
    ms = m_miss(); rd = m_redir(); lh = m_luhit();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (ms) begin
        inm[k] = 1;
        if (mi[k] < cmax[k]) mi[k]++;
      end else begin
        inm[k] = 0;
        if (rd) begin
          bl[k] = 0;
          if (fl[k] < cmax[k]) fl[k]++;
        end else if (bl[k] > 0 || lh) begin
          bl[k] = (bl[k] > 0) ? bl[k] - 1 : lcy[k] - 1;
          if (lu[k] < cmax[k]) lu[k]++;
        end
      end
      if (clr_cnt) begin
        lu[k] = 0; mi[k] = 0; fl[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("d2_outs",  {pw2, iw2, dw2, ew2, iff2, idf2}, m_out(0));
    check("d2_state", st2, m_state(0));
    check("d2_lu",    lu2, lu[0]);
    check("d2_miss",  mi2, mi[0]);
    check("d2_flush", fl2, fl[0]);
    check("d3_outs",  {pw3, iw3, dw3, ew3, iff3, idf3}, m_out(1));
    check("d3_state", st3, m_state(1));
    check("d3_lu",    lu3, lu[1]);
    check("d3_miss",  mi3, mi[1]);
    check("d3_flush", fl3, fl[1]);
  endtask

  // Inputs are set just after a rising edge; outputs checked on the
  // falling edge; the model advances on the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_wr = '0;
    id_rs_used = 0; id_rt_used = 0; ex_memtoreg = 0; branch = 0;
    ex_jumpctrl = 2'd0; icache_stall = 0; dcache_stall = 0; clr_cnt = 0;
  endtask

  task automatic load_use5();
    idle();
    ex_memtoreg = 1; ex_wr = 5'd5; id_rs = 5'd5; id_rs_used = 1;
  endtask

  initial begin
    int r;
    idle();
    rst = 1;
    model_reset();
    #2;
    check("reset_async_state", st2, 2'd0);
    cycle();
    @(posedge clk); #1;
    rst = 0;
    cycle();

    // LU_CYCLES=2 single load-use, two bubbles
    load_use5();
    cycle();
    cycle();
    check("lu2_after_two", lu2, 16'd2);
    idle();
    repeat (3) cycle();

    // register 0 never stalls
    idle();
    ex_memtoreg = 1; ex_wr = 5'd0; id_rs = 5'd0; id_rs_used = 1;
    cycle();
    idle();
    cycle();

    // taken branch outranks a simultaneous load-use
    load_use5();
    ex_jumpctrl = 2'd3; branch = 1;
    cycle();
    idle();
    repeat (2) cycle();

    // LU_CYCLES=3 with a 4-cycle dcache miss during the 2nd bubble
    load_use5();
    cycle();
    idle();
    dcache_stall = 1;
    repeat (4) cycle();
    dcache_stall = 0;
    repeat (4) cycle();

    // saturation on the 4-bit counters, then clear
    icache_stall = 1;
    repeat (20) cycle();
    check("d3_miss_sat", mi3, 4'd15);
    icache_stall = 0;
    clr_cnt = 1;
    cycle();
    clr_cnt = 0;
    check("d3_miss_clr", mi3, 4'd0);
    cycle();

    // reset in the middle of LU_STALL
    load_use5();
    cycle();
    idle();
    #2;
    rst = 1;
    model_reset();
    #1;
    check("rst_mid_state2", st2, 2'd0);
    check("rst_mid_state3", st3, 2'd0);
    check("rst_mid_lu3", lu3, 4'd0);
    cycle();
    rst = 0;
    cycle();
    check("post_rst_pc_write", pw3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_wr       = 5'($urandom_range(0, 3));
      id_rs_used  = 1'($urandom_range(0, 1));
      id_rt_used  = 1'($urandom_range(0, 1));
      ex_memtoreg = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      ex_jumpctrl = (r < 7) ? 2'd0 : 2'(r - 6);
      branch      = 1'($urandom_range(0, 1));
      icache_stall = ($urandom_range(0, 19) == 0);
      dcache_stall = ($urandom_range(0, 14) == 0);
      clr_cnt      = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        model_reset();
      end else begin
        rst = 0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter ADDR_W, default 5, register-specifier width.
REQ-002 Parameter LU_CYCLES, default 1, load-use bubble count; legal range 1..7.
REQ-003 Parameter CNT_W, default 16, performance-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 id_rs, id_rt  in  ADDR_W each  source registers of the instruction in ID.
REQ-007 id_rs_used, id_rt_used  in  1 each  the ID instruction actually reads rs or rt.
REQ-008 ex_wr  in  ADDR_W  destination register of the instruction in EX.
REQ-009 ex_memtoreg  in  1  the EX instruction is a load.
REQ-010 ex_jumpctrl  in  2  jump/branch type of the EX instruction: 00 none, 01 and 10 jumps, 11 conditional branch.
REQ-011 branch  in  1  condition of the branch in EX is taken.
REQ-012 icache_stall, dcache_stall  in  1 each  L1 miss in progress.
REQ-013 clr_cnt  in  1  synchronous clear of all counters.
REQ-014 pc_write, if_write, id_write, exmem_write  out  1 each  pipeline-register enables.
REQ-015 if_flush, id_flush  out  1 each  insert bubble into IF/ID or ID/EX.
REQ-016 state_o  out  2  00 RUN, 01 LU_STALL, 10 MISS.
REQ-017 lu_cnt, miss_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-018 redirect = (ex_jumpctrl==01) | (ex_jumpctrl==10) | (ex_jumpctrl==11 & branch).
REQ-019 luhit = ex_memtoreg & ex_wr!=0 & ((id_rs_used & id_rs==ex_wr) | (id_rt_used & id_rt==ex_wr)).
REQ-020 Register 0 never causes a load-use stall.
REQ-021 Output priority, highest first: miss freeze, then redirect, then load-use, then normal.
REQ-022 Miss freeze (icache_stall|dcache_stall): all four enables 0, both flushes 0.
REQ-023 Redirect: all enables 1, if_flush=1, id_flush=1.
REQ-024 Load-use stall cycle: pc_write=0, if_write=0, id_write=1, exmem_write=1, if_flush=0, id_flush=1.
REQ-025 Normal: all enables 1, both flushes 0.
REQ-026 RUN, luhit, no miss, no redirect: stall this cycle; if LU_CYCLES>1, load remaining counter with LU_CYCLES-1 and go to LU_STALL.
REQ-027 LU_STALL, no miss, no redirect: stall, decrement the remaining counter; at 1, go to RUN; luhit is not re-evaluated.
REQ-028 Total bubbles per load-use = LU_CYCLES exactly; with LU_CYCLES=1, LU_STALL is never entered.
REQ-029 Redirect in LU_STALL: redirect outputs apply; next state RUN; remaining counter cleared.
REQ-030 Any state, miss asserted: next state MISS; the return state and remaining count are saved and frozen.
REQ-031 MISS, miss deasserted: outputs are evaluated per REQ-021 using the saved state; next state follows from the saved state as REQ-026/027.
REQ-032 lu_cnt increments on each load-use stall cycle (not frozen).
REQ-033 miss_cnt increments on each cycle with miss asserted.
REQ-034 flush_cnt increments on each cycle with redirect active and no miss.
REQ-035 All counters saturate at 2^CNT_W-1 and never wrap.
REQ-036 clr_cnt zeroes the counters next edge; it has priority over increment and does not affect the FSM.

Reset
REQ-037 rst asserted, independent of clk: state RUN, remaining counter 0, saved state RUN, all counters 0.
REQ-038 During reset, outputs follow REQ-022..025 with state RUN.
REQ-039 Reset mid-LU_STALL or mid-MISS abandons the operation; no stall persists after release.

Verification
REQ-040 LU_CYCLES=2: ex_memtoreg=1, ex_wr=5, id_rs=5, id_rs_used=1 -> pc_write=0 and id_flush=1 for 2 cycles; state 00,01,00; lu_cnt=2.
REQ-041 ex_memtoreg=1, ex_wr=0, id_rs=0, id_rs_used=1 -> no stall; lu_cnt=0.
REQ-042 ex_jumpctrl=11, branch=1, simultaneous luhit -> if_flush=id_flush=1, pc_write=1; flush_cnt=1; lu_cnt=0.
REQ-043 LU_CYCLES=3, dcache_stall=1 for 4 cycles during the 2nd bubble -> all enables 0; miss_cnt=4; then 2 more bubbles; lu_cnt=3.
REQ-044 CNT_W=4: 20 miss cycles -> miss_cnt=15; clr_cnt=1 -> miss_cnt=0 next cycle.
REQ-045 rst pulse mid-LU_STALL -> state_o=00 immediately; counters 0; pc_write=1 once inputs are idle.
